// File: rtl/xillybus_loopback_fifo_if.sv
// Core-side write/read stream signals of the Xillybus 32-bit loopback FIFO.
// master = the Xillybus core, slave = the FIFO.
interface xillybus_loopback_fifo_if;
  logic [31:0] user_w_write_32_data_w;
  logic        user_w_write_32_wren_w;
  logic        user_w_write_32_open_w;
  logic        user_w_write_32_full_w;
  logic        user_r_read_32_rden_w;
  logic        user_r_read_32_open_w;
  logic [31:0] user_r_read_32_data_w;
  logic        user_r_read_32_empty_w;
  logic        user_r_read_32_eof_w;

  modport master (
    output user_w_write_32_data_w, user_w_write_32_wren_w, user_w_write_32_open_w,
    output user_r_read_32_rden_w, user_r_read_32_open_w,
    input  user_w_write_32_full_w, user_r_read_32_data_w,
    input  user_r_read_32_empty_w, user_r_read_32_eof_w
  );

  modport slave (
    input  user_w_write_32_data_w, user_w_write_32_wren_w, user_w_write_32_open_w,
    input  user_r_read_32_rden_w, user_r_read_32_open_w,
    output user_w_write_32_full_w, user_r_read_32_data_w,
    output user_r_read_32_empty_w, user_r_read_32_eof_w
  );
endinterface

// File: rtl/xillybus_loopback_fifo.sv
// 32-bit loopback FIFO between Xillybus write and read streams, with
// registered read data, sticky error flags and an EOF tracker for write close.
module xillybus_loopback_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                    bus_clk_w,
  input  logic                    trn_reset_n_w,
  xillybus_loopback_fifo_if.slave bus,
  output logic [DEPTH_LOG2:0]     fifo_level,
  output logic                    overflow_sticky,
  output logic                    underflow_sticky
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, EOF_PENDING} eof_state_e;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wopen_q, wopen_d;
  eof_state_e            state_q, state_d;
  logic                  full, empty, wr_acc, rd_acc, flush;

  always_comb begin
    full    = (count_q == DEPTH_CNT);
    empty   = (count_q == '0);
    flush   = !bus.user_w_write_32_open_w && !bus.user_r_read_32_open_w;
    wr_acc  = bus.user_w_write_32_wren_w && !full && !flush;
    rd_acc  = bus.user_r_read_32_rden_w && !empty && !flush;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    ovf_d   = ovf_q | (bus.user_w_write_32_wren_w & full);
    unf_d   = unf_q | (bus.user_r_read_32_rden_w & empty);
    wopen_d = bus.user_w_write_32_open_w;
    state_d = state_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) begin
        rptr_d  = rptr_q + 1'b1;
        rdata_d = mem_q[rptr_q];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // EOF is armed by a falling write-open edge while the reader is still attached.
    unique case (state_q)
      IDLE:
        if (wopen_q && !bus.user_w_write_32_open_w && bus.user_r_read_32_open_w)
          state_d = EOF_PENDING;
      EOF_PENDING:
        if (bus.user_w_write_32_open_w || !bus.user_r_read_32_open_w)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk_w) begin
    if (!trn_reset_n_w) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      wopen_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      wopen_q <= wopen_d;
      state_q <= state_d;
    end
  end

  // Storage has no reset; only the write is suppressed while reset is held.
  always_ff @(posedge bus_clk_w) begin
    if (trn_reset_n_w && wr_acc) mem_q[wptr_q] <= bus.user_w_write_32_data_w;
  end

  assign bus.user_w_write_32_full_w = full;
  assign bus.user_r_read_32_empty_w = empty;
  assign bus.user_r_read_32_data_w  = rdata_q;
  assign bus.user_r_read_32_eof_w   = (state_q == EOF_PENDING) && empty;
  assign fifo_level                 = count_q;
  assign overflow_sticky            = ovf_q;
  assign underflow_sticky           = unf_q;
endmodule

// File: doc/xillybus_loopback_fifo.md
XILLYBUS_LOOPBACK_FIFO -- requirements
Module: xillybus_loopback_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, the log2 of the FIFO depth in 32-bit words (DEPTH = 16).
REQ-002 Port bus_clk_w, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-003 Port trn_reset_n_w, input, 1: synchronous, active-low reset.
REQ-004 Port user_w_write_32_data_w, input, 32: write-stream data from the core.
REQ-005 Port user_w_write_32_wren_w, input, 1: write-stream strobe from the core.
REQ-006 Port user_w_write_32_open_w, input, 1: host write file open.
REQ-007 Port user_w_write_32_full_w, output, 1: FIFO full, to the core.
REQ-008 Port user_r_read_32_rden_w, input, 1: read-stream strobe from the core.
REQ-009 Port user_r_read_32_open_w, input, 1: host read file open.
REQ-010 Port user_r_read_32_data_w, output, 32: read-stream data, to the core.
REQ-011 Port user_r_read_32_empty_w, output, 1: FIFO empty, to the core.
REQ-012 Port user_r_read_32_eof_w, output, 1: end-of-file, to the core.
REQ-013 Port fifo_level, output, DEPTH_LOG2+1: current word count.
REQ-014 Port overflow_sticky, output, 1: a write was attempted while full.
REQ-015 Port underflow_sticky, output, 1: a read was attempted while empty.

Function
REQ-016 Storage SHALL be DEPTH x 32 with write and read pointers of DEPTH_LOG2 bits, wrapping modulo DEPTH.
REQ-017 Count SHALL be DEPTH_LOG2+1 bits, range 0..DEPTH; fifo_level SHALL equal count.
REQ-018 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both decoded from registered count.
REQ-019 A write SHALL be accepted when wren=1 and full=0: store data at wptr, increment wptr.
REQ-020 A write with wren=1 and full=1 SHALL be dropped, leave count unchanged, and set overflow_sticky; a read in the same cycle SHALL NOT admit it.
REQ-021 A read SHALL be accepted when rden=1 and empty=0: user_r_read_32_data_w SHALL present mem[rptr] on the next cycle (one-cycle latency, registered), and rptr SHALL increment.
REQ-022 A read with rden=1 and empty=1 SHALL be ignored, leave data unchanged, and set underflow_sticky; a write in the same cycle SHALL still be accepted (count becomes 1).
REQ-023 Simultaneous accepted read and write SHALL leave count unchanged; otherwise count SHALL change by +1 or -1.
REQ-024 user_r_read_32_data_w SHALL hold its last value between accepted reads.
REQ-025 EOF SHALL use a two-state machine: IDLE and EOF_PENDING.
REQ-026 IDLE SHALL go to EOF_PENDING when user_w_write_32_open_w falls (registered previous value 1, current 0) while user_r_read_32_open_w=1.
REQ-027 EOF_PENDING SHALL go to IDLE when user_w_write_32_open_w=1 or user_r_read_32_open_w=0.
REQ-028 user_r_read_32_eof_w SHALL equal (state == EOF_PENDING) AND empty; residual data SHALL drain before eof asserts.
REQ-029 While user_w_write_32_open_w=0 and user_r_read_32_open_w=0, the FIFO SHALL flush: pointers and count SHALL be 0 on the next cycle, with flush taking priority over any read or write that cycle.
REQ-030 Sticky flags SHALL clear only on reset.

Reset
REQ-031 With trn_reset_n_w=0 at a clock edge, the block SHALL set pointers, count, fifo_level and data to 0, full to 0, empty to 1, eof to 0, sticky flags to 0, state to IDLE, and the registered write_open to 0.
REQ-032 Reset SHALL abort any operation in progress that cycle; storage contents need not clear.

Verification
REQ-033 Both opens=1; write 0x11111111..0x33333333 (3 words), then 3 rdens -> data 0x11111111, 0x22222222, 0x33333333 each one cycle after rden; empty=1 after the third.
REQ-034 Write 16 words -> full=1, fifo_level=16; 17th wren dropped, overflow_sticky=1; read all -> original 16 values in order, pointers wrapped.
REQ-035 Empty FIFO, rden and wren of 0xA5A5A5A5 in the same cycle -> underflow_sticky=1, count=1; next rden returns 0xA5A5A5A5.
REQ-036 2 words queued, write_open falls -> eof=0 until both read, eof=1 with empty=1; write_open rises -> eof=0 next cycle.
REQ-037 5 words queued, both opens drop -> fifo_level=0, empty=1 next cycle; reset pulsed mid-burst -> all outputs at REQ-031 values.
